gray_bin_conv_pipe: RTL and testbench
=====================================

// Module: gray_bin_conv_pipe
// PURPOSE
//  Parametrised, registered Gray<->binary code converter with a valid/ready handshake.
//  - Runtime mode selects the direction per transfer: Gray->binary or binary->Gray.
//  - In Gray->binary mode it checks each accepted Gray word against the previously
//    accepted one, and flags any step where more than one bit changed.
//  - Sits on CDC pointer and encoder paths, where the Gray-code stream must be
//    monitored while it is converted.
// PARAMETERS
//  WIDTH       4   code width in bits (>=2)
//  CHECK_STEP  1   1: single-step checking enabled; 0: step_err and err_count are tied to 0
//  CNT_W       8   width of the saturating error counter
// PORTS
//  clk        in   1        clock; all logic is on the rising edge
//  rst        in   1        synchronous reset, active-high
//  mode       in   1        0: Gray->binary; 1: binary->Gray (sampled on each accepted transfer)
//  in_valid   in   1        din/mode valid
//  in_ready   out  1        block can accept a transfer
//  din        in   WIDTH    input code word
//  out_valid  out  1        dout/step_err valid
//  out_ready  in   1        downstream accepts
//  dout       out  WIDTH    converted word
//  step_err   out  1        qualifies dout: the Gray input differed from the previous one by >1 bit
//  err_count  out  CNT_W    saturating count of step errors since reset
// BEHAVIOUR
//  Reset values (rst=1 at a clock edge):
//  - out_valid=0, dout=0, step_err=0, err_count=0.
//  - Step history is cleared: hist_valid=0, hist=0.
//  - rst overrides every other input in that cycle.
//  - A transfer in flight during reset is dropped.
//  Handshake:
//  - in_ready = !out_valid || out_ready (combinational). It is 0 while rst is high.
//  - accept = in_valid && in_ready. The accepted result appears on dout the next cycle.
//  - Latency is 1 cycle; throughput is 1 word per cycle.
//  Output hold and turnover:
//  - While out_valid=1 and out_ready=0, dout/step_err/out_valid hold stable and in_ready=0.
//  - On out_valid && out_ready && !accept, out_valid goes to 0 next cycle.
//  - A simultaneous accept and drain replaces the output with no bubble.
//  Conversion (registered):
//  - mode=0: dout[WIDTH-1]=din[WIDTH-1]; dout[i]=dout[i+1]^din[i] for i = WIDTH-2 down to 0.
//  - mode=1: dout = din ^ (din >> 1).
//  Step check (CHECK_STEP=1, mode=0 accepts only):
//  - d = popcount(din ^ hist).
//  - step_err <= hist_valid && (d > 1). d==0 (repeat) and d==1 are legal.
//  - Then hist <= din and hist_valid <= 1.
//  - The first accepted word after reset or after a mode change never flags.
//  - An accept with mode=1: step_err <= 0 and hist_valid <= 0.
//  - Wrap-around (e.g. 4'b1000 -> 4'b0000 for WIDTH=4) is a 1-bit change and is legal.
//  - err_count increments on each flagged accept and saturates at 2^CNT_W-1 (no wrap).
//    It counts at accept time, independent of out_ready.
//  - Cycles with no accept leave hist, hist_valid and err_count unchanged.
// TESTING
//  1. WIDTH=4, mode=0, din=4'b1011 -> one cycle later dout=4'b1101, out_valid=1, step_err=0.
//  2. mode=1, din=4'b1101 -> dout=4'b1011. Sweep all 16 values in both modes; check round-trip identity.
//  3. mode=0 stream 0000,0001,0011,0010 -> no step_err. Next 0111 (2 bits changed) -> step_err=1, err_count=1.
//  4. Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, dout held.
//     Release -> next word accepted the same cycle; no loss or duplication.
//  5. mode=0 0101, then mode=1 word, then mode=0 1010 -> no step_err (history cleared).
//     Force 260 errors with CNT_W=8 -> err_count stays at 255.
//  6. Assert rst while out_valid=1 and out_ready=0 -> next cycle all outputs are 0.
//     Then first mode=0 word after reset -> step_err=0.

Source files
------------

// File: rtl/gray_bin_conv_pipe_if.sv
// Handshake bundle for the Gray<->binary converter: upstream word/mode in, converted word and step status out.
interface gray_bin_conv_pipe_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
);
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] din;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;
  logic             step_err;
  logic [CNT_W-1:0] err_count;

  modport master (
    output mode, in_valid, din, out_ready,
    input  in_ready, out_valid, dout, step_err, err_count
  );

  modport slave (
    input  mode, in_valid, din, out_ready,
    output in_ready, out_valid, dout, step_err, err_count
  );
endinterface

// File: rtl/gray_bin_conv_pipe.sv
// Registered Gray<->binary converter with valid/ready handshake and a single-step monitor
// on the Gray input stream (flags and counts multi-bit transitions).
module gray_bin_conv_pipe #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned CHECK_STEP = 1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  gray_bin_conv_pipe_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             out_valid_q;
  logic [WIDTH-1:0] dout_q;
  logic             step_err_q;
  logic [CNT_W-1:0] err_count_q;
  logic [WIDTH-1:0] hist_q;
  logic             hist_valid_q;

  logic             accept;
  logic [WIDTH-1:0] g2b;
  logic [WIDTH-1:0] b2g;
  logic [WIDTH-1:0] diff;
  logic             multi_bit;
  logic             flag;

  assign bus.in_ready  = !rst && (!out_valid_q || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.step_err  = step_err_q;
  assign bus.err_count = err_count_q;

  // Gray->binary: bit i is the XOR of all Gray bits from the MSB down to i.
  always_comb begin
    g2b = '0;
    for (int i = 0; i < WIDTH; i++) begin
      g2b[i] = ^(bus.din >> i);
    end
  end

  assign b2g = bus.din ^ (bus.din >> 1);

  // More than one bit set in diff <=> clearing the lowest set bit leaves something behind.
  assign diff      = bus.din ^ hist_q;
  assign multi_bit = |(diff & (diff - WIDTH'(1)));
  assign flag      = (CHECK_STEP != 0) && hist_valid_q && multi_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      dout_q       <= '0;
      step_err_q   <= 1'b0;
      err_count_q  <= '0;
      hist_q       <= '0;
      hist_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      if (bus.mode) begin
        dout_q       <= b2g;
        step_err_q   <= 1'b0;
        hist_valid_q <= 1'b0;
      end else begin
        dout_q       <= g2b;
        step_err_q   <= flag;
        hist_q       <= bus.din;
        hist_valid_q <= 1'b1;
        if (flag && (err_count_q != CNT_MAX)) begin
          err_count_q <= err_count_q + CNT_W'(1);
        end
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_bin_conv_pipe.sv
// Directed bench for gray_bin_conv_pipe (WIDTH=4, CNT_W=8): vector table, full sweep,
// backpressure, history clearing, counter saturation and reset-in-flight sequences.
module tb_gray_bin_conv_pipe;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 8;

  typedef struct {
    logic             mode;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] exp_dout;
    logic             exp_err;
    logic [CNT_W-1:0] exp_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  gray_bin_conv_pipe_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  gray_bin_conv_pipe #(.WIDTH(WIDTH), .CHECK_STEP(1), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one word for exactly one clock edge; outputs are sampled 1ns after that edge.
  task automatic apply(input logic m, input logic [WIDTH-1:0] d);
    bus.mode     = m;
    bus.din      = d;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] g2b_m(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] b2g_m(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  vec_t vt[14];
  logic [WIDTH-1:0] g;
  logic [CNT_W-1:0] exp_cnt;

  initial begin
    // mode, din, expected dout, expected step_err, expected err_count
    vt[0]  = '{1'b0, 4'b1011, 4'b1101, 1'b0, 8'd0};
    vt[1]  = '{1'b1, 4'b1101, 4'b1011, 1'b0, 8'd0};
    vt[2]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 8'd0};
    vt[3]  = '{1'b0, 4'b0001, 4'b0001, 1'b0, 8'd0};
    vt[4]  = '{1'b0, 4'b0011, 4'b0010, 1'b0, 8'd0};
    vt[5]  = '{1'b0, 4'b0010, 4'b0011, 1'b0, 8'd0};
    vt[6]  = '{1'b0, 4'b0111, 4'b0101, 1'b1, 8'd1};
    vt[7]  = '{1'b0, 4'b0111, 4'b0101, 1'b0, 8'd1};
    vt[8]  = '{1'b0, 4'b0101, 4'b0110, 1'b0, 8'd1};
    vt[9]  = '{1'b1, 4'b0101, 4'b0111, 1'b0, 8'd1};
    vt[10] = '{1'b0, 4'b1010, 4'b1100, 1'b0, 8'd1};
    vt[11] = '{1'b0, 4'b1000, 4'b1111, 1'b0, 8'd1};
    vt[12] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 8'd1};
    vt[13] = '{1'b0, 4'b1111, 4'b1010, 1'b1, 8'd2};

    rst           = 1'b1;
    bus.mode      = 1'b0;
    bus.din       = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_dout", 32'(bus.dout), 32'd0);
    check("rst_err_count", 32'(bus.err_count), 32'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Back-to-back table stream at full throughput.
    for (int k = 0; k < 14; k++) begin
      apply(vt[k].mode, vt[k].din);
      check($sformatf("vec%0d_valid", k), 32'(bus.out_valid), 32'd1);
      check($sformatf("vec%0d_dout", k), 32'(bus.dout), 32'(vt[k].exp_dout));
      check($sformatf("vec%0d_err", k), 32'(bus.step_err), 32'(vt[k].exp_err));
      check($sformatf("vec%0d_cnt", k), 32'(bus.err_count), 32'(vt[k].exp_cnt));
    end
    exp_cnt = 8'd2;

    // Full sweep both directions with round-trip through the DUT.
    for (int v = 0; v < 16; v++) begin
      apply(1'b1, WIDTH'(v));
      check($sformatf("b2g_%0d", v), 32'(bus.dout), 32'(b2g_m(WIDTH'(v))));
      g = bus.dout;
      check($sformatf("g2b_model_%0d", v), 32'(g2b_m(b2g_m(WIDTH'(v)))), 32'(v));
      apply(1'b0, g);
      check($sformatf("roundtrip_%0d", v), 32'(bus.dout), 32'(v));
      check($sformatf("roundtrip_err_%0d", v), 32'(bus.step_err), 32'd0);
    end
    check("sweep_cnt", 32'(bus.err_count), 32'(exp_cnt));

    // Backpressure: output held, no acceptance, release accepts in the same cycle.
    apply(1'b1, 4'h3);
    check("bp_first", 32'(bus.dout), 32'h2);
    bus.out_ready = 1'b0;
    bus.mode      = 1'b1;
    bus.din       = 4'h9;
    bus.in_valid  = 1'b1;
    #1;
    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_hold_dout%0d", c), 32'(bus.dout), 32'h2);
      check($sformatf("bp_hold_valid%0d", c), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp_hold_ready%0d", c), 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp_release_dout", 32'(bus.dout), 32'hD);
    check("bp_release_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #1;
    check("bp_drain_valid", 32'(bus.out_valid), 32'd0);
    check("bp_drain_dout", 32'(bus.dout), 32'hD);

    // Saturation: 260 four-bit jumps after a seeding word.
    apply(1'b0, 4'b0000);
    check("sat_seed_err", 32'(bus.step_err), 32'd0);
    for (int k = 0; k < 260; k++) begin
      apply(1'b0, (k % 2 == 0) ? 4'b1111 : 4'b0000);
      if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      if (k == 100 || k == 259) begin
        check($sformatf("sat_err_%0d", k), 32'(bus.step_err), 32'd1);
        check($sformatf("sat_cnt_%0d", k), 32'(bus.err_count), 32'(exp_cnt));
      end
    end
    check("sat_cnt_final", 32'(bus.err_count), 32'd255);

    // Reset while the output is stalled drops everything.
    bus.out_ready = 1'b0;
    apply(1'b0, 4'b0101);
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("rst_comb_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    check("post_rst_valid", 32'(bus.out_valid), 32'd0);
    check("post_rst_dout", 32'(bus.dout), 32'd0);
    check("post_rst_err", 32'(bus.step_err), 32'd0);
    check("post_rst_cnt", 32'(bus.err_count), 32'd0);
    apply(1'b0, 4'b1111);
    check("post_rst_first_err", 32'(bus.step_err), 32'd0);
    check("post_rst_first_dout", 32'(bus.dout), 32'b1010);
    apply(1'b0, 4'b0000);
    check("post_rst_second_err", 32'(bus.step_err), 32'd1);
    check("post_rst_second_cnt", 32'(bus.err_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
